// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 multiplexer: steps the select over the enabled channels,
// samples mux_out after a settle time and publishes the assembled byte with busy/done.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] mask,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] data
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state_r;
  logic [2:0] ch_r;
  logic [3:0] cnt_r;
  logic [7:0] mask_r;
  logic [7:0] shadow_r;
  logic [2:0] sel_r;
  logic       busy_r;
  logic       done_r;
  logic [7:0] data_r;

  logic [2:0] first_ch_s;
  logic [2:0] next_ch_s;
  logic       next_found_s;
  logic [7:0] sampled_s;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Returns {found, index} of the lowest enabled channel strictly above cur.
  function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Channel search and shadow update with the bit being sampled this cycle.
  always_comb begin
    first_ch_s              = lowest_set(mask);
    {next_found_s, next_ch_s} = next_above(mask_r, ch_r);
    sampled_s               = shadow_r;
    sampled_s[ch_r]         = mux_out;
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ch_r     <= 3'd0;
      cnt_r    <= 4'd0;
      mask_r   <= 8'h00;
      shadow_r <= 8'h00;
      sel_r    <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      data_r   <= 8'h00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          sel_r  <= 3'd0;
          busy_r <= 1'b0;
          if (start) begin
            mask_r   <= mask;
            shadow_r <= 8'h00;
            if (mask == 8'h00) begin
              done_r <= 1'b1;
              data_r <= 8'h00;
            end else begin
              state_r <= SCAN;
              ch_r    <= first_ch_s;
              sel_r   <= first_ch_s;
              cnt_r   <= SETTLE_CNT;
              busy_r  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            sel_r    <= 3'd0;
            shadow_r <= 8'h00;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            shadow_r <= sampled_s;
            if (next_found_s) begin
              ch_r  <= next_ch_s;
              sel_r <= next_ch_s;
              cnt_r <= SETTLE_CNT;
            end else begin
              data_r  <= sampled_s;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              sel_r   <= 3'd0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          sel_r   <= 3'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = sel_r;
  assign busy = busy_r;
  assign done = done_r;
  assign data = data_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: table of scans checked against a mask/popcount model,
// plus abort, reset, start-while-busy and back-to-back sequences.
module tb_mux_scan_ctrl;

  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [7:0] mask1 = 8'h00, mux_in1 = 8'h00;
  logic       mux_out1;
  logic [2:0] sel1;
  logic       busy1, done1;
  logic [7:0] data1;

  logic       start0 = 1'b0, abort0 = 1'b0;
  logic [7:0] mask0 = 8'h00, mux_in0 = 8'h00;
  logic       mux_out0;
  logic [2:0] sel0;
  logic       busy0, done0;
  logic [7:0] data0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mux_out1 = mux_in1[sel1];
  assign mux_out0 = mux_in0[sel0];

  mux_scan_ctrl #(.SETTLE(S1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mask(mask1),
    .mux_out(mux_out1), .sel(sel1), .busy(busy1), .done(done1), .data(data1)
  );

  mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .mask(mask0),
    .mux_out(mux_out0), .sel(sel0), .busy(busy0), .done(done0), .data(data0)
  );

  typedef struct {
    logic [7:0] iv;
    logic [7:0] m;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full scan on the SETTLE=1 instance; the select sequence is rebuilt from the mask.
  task automatic run_scan(input vec_t v, input string tag);
    logic [2:0] chans[$];
    logic [7:0] prev_data;
    int         done_at, busy_cnt;
    bit         sel_ok, hold_ok;
    chans = {};
    for (int k = 0; k < 8; k++) if (v.m[k]) chans.push_back(3'(k));
    @(negedge clk);
    mux_in1 = v.iv; mask1 = v.m; start1 = 1'b1;
    prev_data = data1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    mask1  = 8'($urandom);
    done_at = -1; busy_cnt = 0; sel_ok = 1'b1; hold_ok = 1'b1;
    for (int j = 0; j < v.exp_lat + 4; j++) begin
      if (j > 0) @(negedge clk);
      if (busy1) busy_cnt++;
      if (j < v.exp_lat) begin
        if (sel1 !== chans[j / (S1 + 1)]) sel_ok = 1'b0;
        if (data1 !== prev_data) hold_ok = 1'b0;
      end else if (sel1 !== 3'd0) begin
        sel_ok = 1'b0;
      end
      if (done1) done_at = (done_at < 0) ? j : 1000;
    end
    check({tag, "_latency"}, done_at, v.exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, v.exp_lat);
    check({tag, "_sel_seq"}, {31'd0, sel_ok}, 32'd1);
    check({tag, "_data_hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_data"}, data1, v.exp_data);
  endtask

  initial begin
    int         dcnt, d1, d2, d3, j;
    logic [7:0] prev;

    vecs[0] = '{8'hA5, 8'hFF, 8'hA5, 16};
    vecs[1] = '{8'hFF, 8'h81, 8'h81, 4};
    vecs[2] = '{8'h77, 8'h00, 8'h00, 0};
    vecs[3] = '{8'h10, 8'h10, 8'h10, 2};
    for (int i = 4; i < 12; i++) begin
      vecs[i].iv       = 8'($urandom);
      vecs[i].m        = 8'($urandom);
      vecs[i].exp_data = vecs[i].iv & vecs[i].m;
      vecs[i].exp_lat  = $countones(vecs[i].m) * (S1 + 1);
    end

    repeat (2) @(negedge clk);
    check("rst_sel", sel1, 3'd0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_data", data1, 8'h00);
    check("rst_data_s0", data0, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    // Abort five cycles after start: no done, data keeps its previous value.
    prev = data1;
    @(negedge clk);
    mux_in1 = 8'h3C; mask1 = 8'hFF; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("abort_busy", busy1, 1'b0);
    check("abort_sel", sel1, 3'd0);
    check("abort_data", data1, prev);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done1) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    run_scan('{8'h3C, 8'hFF, 8'h3C, 16}, "after_abort");

    // Reset mid-scan.
    @(negedge clk);
    mux_in1 = 8'hA5; mask1 = 8'hFF; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_sel", sel1, 3'd0);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_done", done1, 1'b0);
    check("midrst_data", data1, 8'h00);

    // Start pulse while busy is ignored: exactly one done.
    @(negedge clk);
    mux_in1 = 8'h09; mask1 = 8'h0F; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      start1 = (k == 2);
      if (done1) dcnt++;
      @(negedge clk);
    end
    start1 = 1'b0;
    check("busy_start_done_count", dcnt, 1);
    check("busy_start_data", data1, 8'h09);

    // SETTLE=0 with start held: back-to-back scans, one IDLE (done) cycle between them.
    @(negedge clk);
    mux_in0 = 8'h5A; mask0 = 8'hFF; start0 = 1'b1;
    j = 0; d1 = -1; d2 = -1; d3 = -1;
    while (j < 60 && d1 < 0) begin
      @(negedge clk);
      if (done0) d1 = j;
      j++;
    end
    check("b2b_first_lat", d1, 8);
    check("b2b_data1", data0, 8'h5A);
    mux_in0 = 8'h0F;
    while (j < 120 && d2 < 0) begin
      @(negedge clk);
      if (done0) d2 = j;
      j++;
    end
    check("b2b_period1", d2 - d1, 9);
    check("b2b_data2", data0, 8'h0F);
    while (j < 180 && d3 < 0) begin
      @(negedge clk);
      if (done0) d3 = j;
      j++;
    end
    check("b2b_period2", d3 - d2, 9);
    check("b2b_data3", data0, 8'h0F);
    start0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
